// File: rtl/hangman_pkg.sv
// Shared constants for the hangman datapath: widths, letter codes and the
// secret-word table.
package hangman_pkg;

    localparam int WORD_LEN  = 5;
    localparam int CHAR_W    = 5;
    localparam int NUM_WORDS = 8;
    localparam int MAX_TRIES = 6;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam int TRIES_W   = 3;
    localparam int WORD_W    = WORD_LEN * CHAR_W;

    typedef logic [CHAR_W-1:0] char_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam char_t CH_NONE = 5'd0;
    localparam char_t CH_A = 5'd1,  CH_B = 5'd2,  CH_C = 5'd3,  CH_D = 5'd4;
    localparam char_t CH_E = 5'd5,  CH_F = 5'd6,  CH_G = 5'd7,  CH_H = 5'd8;
    localparam char_t CH_I = 5'd9,  CH_J = 5'd10, CH_K = 5'd11, CH_L = 5'd12;
    localparam char_t CH_M = 5'd13, CH_N = 5'd14, CH_O = 5'd15, CH_P = 5'd16;
    localparam char_t CH_Q = 5'd17, CH_R = 5'd18, CH_S = 5'd19, CH_T = 5'd20;
    localparam char_t CH_U = 5'd21, CH_V = 5'd22, CH_W = 5'd23, CH_X = 5'd24;
    localparam char_t CH_Y = 5'd25, CH_Z = 5'd26;

    // Letters are written in reading order; letter 0 lands in the low bits.
    function automatic word_t mk_word(input char_t c0, input char_t c1,
                                      input char_t c2, input char_t c3,
                                      input char_t c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    localparam word_t WORD_TABLE [NUM_WORDS] = '{
        mk_word(CH_A, CH_P, CH_P, CH_L, CH_E),
        mk_word(CH_L, CH_E, CH_V, CH_E, CH_L),
        mk_word(CH_B, CH_R, CH_A, CH_I, CH_N),
        mk_word(CH_C, CH_H, CH_I, CH_P, CH_S),
        mk_word(CH_G, CH_A, CH_T, CH_E, CH_S),
        mk_word(CH_C, CH_L, CH_O, CH_C, CH_K),
        mk_word(CH_L, CH_O, CH_G, CH_I, CH_C),
        mk_word(CH_T, CH_I, CH_M, CH_E, CH_R)
    };

endpackage

// File: rtl/hangman_word_rom.sv
// Combinational word table lookup: index -> packed word, letter 0 in [4:0].
module hangman_word_rom
    import hangman_pkg::*;
(
    input  logic [IDX_W-1:0]  index,
    output logic [WORD_W-1:0] word
);

    assign word = WORD_TABLE[index];

endmodule

// File: rtl/hangman_datapath.sv
// Hangman datapath: word selection, guess latch, revealed-letter mask,
// tries counter and win/lose flags, all driven by controller strobes.
module hangman_datapath
    import hangman_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [CHAR_W-1:0]   char_in,
    input  logic                en_input_char,
    input  logic                en_word_index,
    input  logic                s_guessed_letters,
    input  logic                en_guessed_letters,
    input  logic                s_tries,
    input  logic                en_tries,
    input  logic                s_win,
    input  logic                en_win,
    input  logic                s_lose,
    input  logic                en_lose,
    output logic [WORD_LEN-1:0] input_char_eq_word,
    output logic                already_guessed,
    output logic                guessed_letters_is_done,
    output logic                tries_zero,
    output logic [TRIES_W-1:0]  tries,
    output logic [WORD_LEN-1:0] guessed_letters,
    output logic                win,
    output logic                lose
);

    logic [IDX_W-1:0]  word_index;
    logic [CHAR_W-1:0] input_char;
    logic [WORD_W-1:0] word;
    logic              char_valid;

    hangman_word_rom u_rom (
        .index (word_index),
        .word  (word)
    );

    // Codes 0 and 27..31 never match, even if a table slot held them.
    assign char_valid = (input_char != CH_NONE) && (input_char <= CH_Z);

    for (genvar i = 0; i < WORD_LEN; i++) begin : g_match
        assign input_char_eq_word[i] =
            char_valid && (input_char == word[i*CHAR_W +: CHAR_W]);
    end

    assign already_guessed         = |(input_char_eq_word & guessed_letters);
    assign guessed_letters_is_done = &guessed_letters;
    assign tries_zero              = (tries == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            word_index      <= '0;
            input_char      <= '0;
            guessed_letters <= '0;
            tries           <= '0;
            win             <= 1'b0;
            lose            <= 1'b0;
        end else begin
            if (en_word_index)
                word_index <= word_index + 1'b1;
            if (en_input_char)
                input_char <= char_in;
            if (en_guessed_letters) begin
                if (s_guessed_letters)
                    guessed_letters <= '0;
                else
                    guessed_letters <= guessed_letters | input_char_eq_word;
            end
            // Decrement saturates so a late wrong guess cannot wrap to 7.
            if (en_tries) begin
                if (s_tries)
                    tries <= TRIES_W'(MAX_TRIES);
                else if (tries != '0)
                    tries <= tries - 1'b1;
            end
            if (en_win)
                win <= s_win;
            if (en_lose)
                lose <= s_lose;
        end
    end

endmodule
